// File: rtl/mem_if_pkg.sv
// Shared definitions for the responder side of the CPU memory interface.
//   - state_e          : responder FSM encoding (IDLE / WAIT / RESP)
//   - CNT_W            : width of the wait-cycle counter
//   - LATENCY_MAX      : largest latency the counter can express
//   - WORD_ALIGN_MASK  : byte-address bits that must be zero for a word access
//   - addr_error()     : misalignment / out-of-range check for a byte address
package mem_if_pkg;

    localparam int CNT_W       = 4;
    localparam int LATENCY_MAX = (1 << CNT_W) - 1;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // A byte address is bad when it is not word aligned or when any bit
    // above the word-index field is set.
    function automatic logic addr_error(input logic [31:0] addr, input int addr_bits);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr & WORD_ALIGN_MASK) != 32'd0;
        out_of_range = (addr >> (addr_bits + 2)) != 32'd0;
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: 2^ADDR_BITS x 32 bits.
// Ports:
//   clk      : clock, writes land on the rising edge
//   wr_en    : write enable
//   wr_addr  : word index to write
//   wr_data  : data to write
//   rd_addr  : word index to read
//   rd_data  : combinational read of rd_addr
// Contents are not reset.
module mem_array #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [31:0]          rd_data
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle word memory target with a req/ack handshake.
// A request sampled in IDLE is captured, held for LATENCY wait cycles and
// answered with a single-cycle ack carrying read data and an error flag.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset
//   req   : request valid, sampled only in IDLE
//   we    : 1 = write, 0 = read (captured with req)
//   addr  : byte address (captured with req)
//   wd    : write data (captured with req)
//   rd    : read data, valid while ack=1, otherwise 0
//   ack   : one-cycle response strobe
//   err   : error flag, valid while ack=1
//   busy  : high in WAIT and RESP
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    generate
        if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("mem_responder: LATENCY must be within 0..15");
        end
        if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
            $error("mem_responder: ADDR_BITS must be within 1..30");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   word_addr_q, word_addr_d;
    logic [31:0]            wd_q, wd_d;
    logic                   err_cap_q, err_cap_d;
    logic [31:0]            rd_q, rd_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic                   capture;
    logic                   req_err;
    logic                   mem_wr_en;
    logic [31:0]            mem_rdata;

    assign capture = (state_q == IDLE) && req;
    assign req_err = addr_error(addr, ADDR_BITS);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request capture and wait counter ----------------
    // The *_d values equal the incoming request in the capture cycle and the
    // held request otherwise, so they are the request the response is built
    // from. With LATENCY=0 this lets the response register load directly at
    // the capture edge.
    always_comb begin
        we_d        = we_q;
        word_addr_d = word_addr_q;
        wd_d        = wd_q;
        err_cap_d   = err_cap_q;
        cnt_d       = cnt_q;
        if (capture) begin
            we_d        = we;
            word_addr_d = addr[ADDR_BITS+1:2];
            wd_d        = wd;
            err_cap_d   = req_err;
            cnt_d       = LAT_CNT;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // ---------------- output logic ----------------
    // Outputs are registered: they are loaded on the edge that enters the
    // state they describe, so ack/rd/err are high exactly during RESP.
    always_comb begin
        ack_d  = (state_d == RESP);
        busy_d = (state_d != IDLE);
        err_d  = (state_d == RESP) && err_cap_d;
        rd_d   = '0;
        if ((state_d == RESP) && !we_d && !err_cap_d) begin
            rd_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            we_q        <= 1'b0;
            word_addr_q <= '0;
            wd_q        <= '0;
            err_cap_q   <= 1'b0;
            rd_q        <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            word_addr_q <= word_addr_d;
            wd_q        <= wd_d;
            err_cap_q   <= err_cap_d;
            rd_q        <= rd_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // Writes commit only at the end of RESP, so a reset during WAIT drops
    // the pending write.
    assign mem_wr_en = (state_q == RESP) && we_q && !err_cap_q;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (word_addr_q),
        .wr_data (wd_q),
        .rd_addr (word_addr_d),
        .rd_data (mem_rdata)
    );

    assign rd   = rd_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [31:0] addr_a = '0, wd_a = '0;
    logic [31:0] rd_a;
    logic        ack_a, err_a, busy_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_b = '0, wd_b = '0;
    logic [31:0] rd_b;
    logic        ack_b, err_b, busy_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wd(wd_a),
        .rd(rd_a), .ack(ack_a), .err(err_a), .busy(busy_a)
    );

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wd(wd_b),
        .rd(rd_b), .ack(ack_b), .err(err_b), .busy(busy_b)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] ma[int];
    logic [31:0] mb[int];
    exp_t        ea, eb;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    endfunction

    // Scoreboard monitors: every ack must match the oldest expected response.
    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            $display("[TB] A ack cyc=%0d rd=0x%08h err=%0b", cyc, rd_a, err_a);
            if (qa.size() == 0) begin
                check("a_unexpected_ack", 32'(ack_a), 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_rd", rd_a, ea.rd);
                check("a_err", 32'(err_a), 32'(ea.err));
                check("a_ack_cycle", 32'(cyc), 32'(ea.cyc));
                check("a_busy_in_ack", 32'(busy_a), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (ack_b === 1'b1) begin
            $display("[TB] B ack cyc=%0d rd=0x%08h err=%0b", cyc, rd_b, err_b);
            if (qb.size() == 0) begin
                check("b_unexpected_ack", 32'(ack_b), 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_rd", rd_b, eb.rd);
                check("b_err", 32'(err_b), 32'(eb.err));
                check("b_ack_cycle", 32'(cyc), 32'(eb.cyc));
                check("b_busy_in_ack", 32'(busy_b), 32'd1);
            end
        end
    end

    // Build the expected response for a request from the bench's own model.
    function automatic exp_t make_exp(input bit on_b, input logic w, input logic [31:0] a, input int c);
        exp_t e;
        int   idx;
        idx   = int'(a[9:2]);
        e.err = exp_err(a);
        if (w || e.err) e.rd = 32'd0;
        else if (on_b)  e.rd = mb[idx];
        else            e.rd = ma[idx];
        e.cyc = c + 1 + (on_b ? LAT_B : LAT_A);
        return e;
    endfunction

    // One request: req for a single sample edge, expected response queued.
    task automatic issue(input bit on_b, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        e = make_exp(on_b, w, a, cyc);
        if (on_b) begin
            check("b_busy_before_req", 32'(busy_b), 32'd0);
            req_b = 1'b1; we_b = w; addr_b = a; wd_b = d;
            qb.push_back(e);
            if (w && !e.err) mb[int'(a[9:2])] = d;
        end else begin
            check("a_busy_before_req", 32'(busy_a), 32'd0);
            req_a = 1'b1; we_a = w; addr_a = a; wd_a = d;
            qa.push_back(e);
            if (w && !e.err) ma[int'(a[9:2])] = d;
        end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("pending_responses", 32'(qa.size() + qb.size()), 32'd0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int   c;
        exp_t e;

        // Reset held for three cycles, then released.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("a_reset_ack",  32'(ack_a),  32'd0);
        check("a_reset_busy", 32'(busy_a), 32'd0);
        check("a_reset_rd",   rd_a,        32'd0);
        check("a_reset_err",  32'(err_a),  32'd0);
        check("b_reset_ack",  32'(ack_b),  32'd0);
        check("b_reset_busy", 32'(busy_b), 32'd0);
        check("b_reset_rd",   rd_b,        32'd0);
        check("b_reset_err",  32'(err_b),  32'd0);

        // Write then read, LATENCY=2.
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF); drain();
        issue(1'b0, 1'b0, 32'h10, 32'h0);        drain();
        issue(1'b0, 1'b1, 32'h14, 32'hCAFEF00D); drain();

        // LATENCY=0: ack one cycle after the sample edge, busy only then.
        issue(1'b1, 1'b1, 32'h0, 32'h12345678);  drain();
        @(negedge clk);
        #1;
        check("b_busy_after_ack", 32'(busy_b), 32'd0);
        issue(1'b1, 1'b0, 32'h0, 32'h0);         drain();
        issue(1'b1, 1'b0, 32'h402, 32'h0);       drain();

        // Error paths.
        issue(1'b0, 1'b1, 32'h13, 32'h0BADF00D); drain();
        issue(1'b0, 1'b0, 32'h10, 32'h0);        drain();
        issue(1'b0, 1'b0, 32'h400, 32'h0);       drain();

        // Back-to-back with req held high through two transactions.
        @(negedge clk);
        c = cyc;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h10;
        e = make_exp(1'b0, 1'b0, 32'h10, c);
        qa.push_back(e);
        e = make_exp(1'b0, 1'b0, 32'h14, c + LAT_A + 2);
        qa.push_back(e);
        repeat (3) @(negedge clk);   // first ack cycle
        addr_a = 32'h14;             // picked up by the next IDLE sample
        repeat (2) @(negedge clk);   // second request in WAIT
        req_a = 1'b0;
        #1;
        drain();

        // A write pulse during WAIT must be ignored.
        @(negedge clk);
        c = cyc;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h10;
        e = make_exp(1'b0, 1'b0, 32'h10, c);
        qa.push_back(e);
        @(negedge clk);
        we_a = 1'b1; addr_a = 32'h10; wd_a = 32'hBAD0BAD0;
        @(negedge clk);
        req_a = 1'b0; we_a = 1'b0;
        #1;
        drain();
        repeat (6) @(negedge clk);
        issue(1'b0, 1'b0, 32'h10, 32'h0);        drain();

        // Reset during WAIT aborts a pending write.
        issue(1'b0, 1'b1, 32'h20, 32'h11111111); drain();
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wd_a = 32'hAAAA5555;
        @(negedge clk);
        req_a = 1'b0; we_a = 1'b0;
        check("a_busy_in_wait", 32'(busy_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("a_async_reset_busy", 32'(busy_a), 32'd0);
        check("a_async_reset_ack",  32'(ack_a),  32'd0);
        check("a_async_reset_rd",   rd_a,        32'd0);
        check("a_async_reset_err",  32'(err_a),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 1'b0, 32'h20, 32'h0);        drain();

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
